// File: rtl/a2d_pkg.sv
// Shared A2D definitions: sequencer states and SPI command framing for the external ADC.
package a2d_pkg;

  localparam int unsigned SPI_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DEAD = 2'd2,
    RD   = 2'd3
  } a2d_state_t;

  localparam logic [1:0]       CMD_PREFIX = 2'b00;
  localparam logic [10:0]      CMD_PAD    = 11'b0;
  localparam logic [SPI_W-1:0] RD_FRAME   = 16'h0000;

  // Command frame that selects an ADC channel for the following read frame
  function automatic logic [SPI_W-1:0] cmd_frame(input logic [2:0] ch);
    return {CMD_PREFIX, ch, CMD_PAD};
  endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// SPI monarch: 16-bit full-duplex frame, MSB first, SCLK = clk/8, sample MISO mid-low phase.
module SPI_mnrch
  import a2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [SPI_W-1:0] wrt_data,
  input  logic             MISO,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  output logic             done,
  output logic [SPI_W-1:0] rd_data
);

  localparam int unsigned DIV_W = 3;
  localparam int unsigned CNT_W = 4;

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] bit_cnt;
  logic [SPI_W-1:0] shft;
  logic             active;
  logic             miso_smpl;

  // div idles at 0, so its MSB doubles as a glitch-free SCLK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      bit_cnt   <= '0;
      shft      <= '0;
      active    <= 1'b0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (wrt) begin
          active  <= 1'b1;
          SS_n    <= 1'b0;
          shft    <= wrt_data;
          div     <= '0;
          bit_cnt <= '0;
        end
      end else begin
        div <= div + DIV_W'(1);
        if (div == DIV_W'(3)) miso_smpl <= MISO;
        if (&div) begin
          shft    <= {shft[SPI_W-2:0], miso_smpl};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (&bit_cnt) begin
            active <= 1'b0;
            SS_n   <= 1'b1;
            done   <= 1'b1;
          end
        end
      end
    end
  end

  assign SCLK    = div[DIV_W-1];
  assign MOSI    = shft[SPI_W-1];
  assign rd_data = shft;

endmodule

// File: rtl/a2d_rr_sampler.sv
// Round-robin ADC sampler: command/read SPI pair per slot, optional per-slot IIR, latest value per slot.
module a2d_rr_sampler
  import a2d_pkg::*;
#(
  parameter int unsigned           NUM_CH    = 4,
  parameter logic [3*NUM_CH-1:0]   CH_MAP    = {3'd6, 3'd5, 3'd4, 3'd0},
  parameter int unsigned           DATA_W    = 12,
  parameter int unsigned           AVG_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nxt,
  input  logic                       auto_en,
  output logic [NUM_CH*DATA_W-1:0]   results,
  output logic [NUM_CH-1:0]          smpl_vld,
  output logic                       busy,
  output logic                       SS_n,
  output logic                       SCLK,
  output logic                       MOSI,
  input  logic                       MISO
);

  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W  = DATA_W + AVG_SHIFT;

  a2d_state_t        state, state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [2:0]        cur_ch;
  logic              wrt_c;
  logic [SPI_W-1:0]  wrt_data_c;
  logic              done;
  logic [SPI_W-1:0]  rd_data;
  logic [DATA_W-1:0] sample;
  logic              cap_c;
  logic              unused_rd;

  assign cur_ch    = CH_MAP[3*int'(slot) +: 3];
  assign sample    = rd_data[DATA_W-1:0];
  assign unused_rd = ^rd_data;
  assign cap_c     = (state == RD) && done;

  SPI_mnrch u_spi (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt      (wrt_c),
    .wrt_data (wrt_data_c),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .done     (done),
    .rd_data  (rd_data)
  );

  // Next-state and SPI launch decode
  always_comb begin
    state_nxt  = state;
    wrt_c      = 1'b0;
    wrt_data_c = RD_FRAME;
    case (state)
      IDLE: if (nxt || auto_en) begin
        wrt_c      = 1'b1;
        wrt_data_c = cmd_frame(cur_ch);
        state_nxt  = CMD;
      end
      CMD:  if (done) state_nxt = DEAD;
      DEAD: begin
        wrt_c      = 1'b1;
        wrt_data_c = RD_FRAME;
        state_nxt  = RD;
      end
      RD:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot     <= '0;
      busy     <= 1'b0;
      smpl_vld <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      smpl_vld <= '0;
      if (cap_c) begin
        smpl_vld[slot] <= 1'b1;
        slot <= (slot == SLOT_W'(NUM_CH-1)) ? '0 : slot + SLOT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    logic hit_c;
    assign hit_c = cap_c && (slot == SLOT_W'(i));

    if (AVG_SHIFT == 0) begin : g_raw
      logic [DATA_W-1:0] res_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     res_q <= '0;
        else if (hit_c) res_q <= sample;
      end
      assign results[DATA_W*i +: DATA_W] = res_q;
    end else begin : g_iir
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] acc_nxt_c;
      logic             primed;
      // First sample seeds the accumulator so the filter does not ramp up from zero
      always_comb begin
        acc_nxt_c = ACC_W'(sample) << AVG_SHIFT;
        if (primed) acc_nxt_c = acc + ACC_W'(sample) - (acc >> AVG_SHIFT);
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc    <= '0;
          primed <= 1'b0;
        end else if (hit_c) begin
          acc    <= acc_nxt_c;
          primed <= 1'b1;
        end
      end
      assign results[DATA_W*i +: DATA_W] = acc[ACC_W-1 -: DATA_W];
    end
  end

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Scoreboard bench: two sampler configs share stimulus; an ADC model per config predicts each update.
module tb_a2d_rr_sampler;

  localparam int NCFG = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic nxt = 1'b0;
  logic auto_en = 1'b0;
  logic force_mode = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic        busy_w [NCFG];
  logic        ssn_w  [NCFG];
  logic        zero_w [NCFG];
  logic [7:0]  vld_w  [NCFG];
  logic [15:0] r0_w   [NCFG];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int unsigned NC    = (g == 0) ? 4 : 3;
    localparam int unsigned DW    = (g == 0) ? 12 : 11;
    localparam int unsigned SH    = (g == 0) ? 0 : 2;
    localparam logic [11:0] MAP12 = (g == 0) ? 12'o6540 : 12'o0371;

    logic [NC*DW-1:0] results;
    logic [NC-1:0]    smpl_vld;
    logic             busy, SS_n, SCLK, MOSI;
    logic             MISO = 1'b0;

    a2d_rr_sampler #(.NUM_CH(NC), .CH_MAP(MAP12[3*NC-1:0]), .DATA_W(DW), .AVG_SHIFT(SH)) u_dut (
      .clk(clk), .rst_n(rst_n), .nxt(nxt), .auto_en(auto_en), .results(results),
      .smpl_vld(smpl_vld), .busy(busy), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    assign busy_w[g] = busy;
    assign ssn_w[g]  = SS_n;
    assign zero_w[g] = (results == '0);
    assign vld_w[g]  = 8'(smpl_vld);
    assign r0_w[g]   = 16'(results[DW-1:0]);

    // Reference model state: expected slot rotation, filter state, visible results
    int               slot_m = 0;
    int               visits0 = 0;
    bit               primed_m [NC];
    longint           acc_m [NC];
    logic [NC*DW-1:0] res_m = '0;
    logic [NC*DW-1:0] exp_res_q [$];
    int               exp_slot_q [$];

    // ADC slave: command frame names a channel, next frame returns its conversion
    initial begin : slave
      logic p_ss, p_sck, expect_rd;
      logic [15:0] rx, tx;
      int bitn;
      int unsigned v;
      longint r;
      p_ss = 1'b1; p_sck = 1'b0; expect_rd = 1'b0; rx = '0; tx = '0; bitn = 0;
      forever begin
        @(SS_n or SCLK or rst_n);
        if (rst_n !== 1'b1) begin
          slot_m = 0; res_m = '0; visits0 = 0; expect_rd = 1'b0; bitn = 0;
          for (int i = 0; i < NC; i++) begin primed_m[i] = 1'b0; acc_m[i] = 0; end
        end else if (p_ss === 1'b1 && SS_n === 1'b0) begin
          bitn = 0; rx = '0;
          tx = 16'($urandom);
          if (expect_rd) begin
            v = $urandom & ((32'd1 << DW) - 1);
            if (force_mode && slot_m == 0) v = (g == 0) ? 32'hA5A : ((visits0 == 0) ? 32'h400 : 32'h0);
            tx = (tx & ~16'((32'd1 << DW) - 1)) | 16'(v);
            if (SH == 0) r = longint'(v);
            else begin
              if (!primed_m[slot_m]) acc_m[slot_m] = longint'(v) * (2 ** SH);
              else acc_m[slot_m] = acc_m[slot_m] + longint'(v) - acc_m[slot_m] / (2 ** SH);
              primed_m[slot_m] = 1'b1;
              r = acc_m[slot_m] / (2 ** SH);
            end
            res_m[slot_m*DW +: DW] = DW'(r);
            exp_res_q.push_back(res_m);
            exp_slot_q.push_back(slot_m);
            if (slot_m == 0) visits0++;
            slot_m = (slot_m + 1) % NC;
          end
          MISO = tx[15];
        end else if (p_ss === 1'b0 && SS_n === 1'b1) begin
          if (bitn == 16 && !expect_rd) begin
            check($sformatf("cfg%0d cmd frame", g), 64'(rx), 64'({2'b00, MAP12[3*slot_m +: 3], 11'b0}));
            expect_rd = 1'b1;
          end else if (bitn == 16) begin
            check($sformatf("cfg%0d read frame", g), 64'(rx), 64'h0);
            expect_rd = 1'b0;
          end else expect_rd = 1'b0;
        end else if (SS_n === 1'b0 && p_sck === 1'b0 && SCLK === 1'b1 && bitn < 16) begin
          rx = {rx[14:0], MOSI};
          bitn++;
        end else if (SS_n === 1'b0 && p_sck === 1'b1 && SCLK === 1'b0 && bitn < 16) begin
          tx = tx << 1;
          MISO = tx[15];
        end
        p_ss = SS_n; p_sck = SCLK;
      end
    end

    // Monitor: every update strobe must match the oldest predicted update
    always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
        exp_res_q.delete();
        exp_slot_q.delete();
      end else if (smpl_vld !== '0) begin
        if (exp_res_q.size() == 0) begin
          n_chk++;
          $display("FAIL cfg%0d spurious smpl_vld: got %b expected none", g, smpl_vld);
        end else begin
          int s;
          logic [NC*DW-1:0] rexp;
          s = exp_slot_q.pop_front();
          rexp = exp_res_q.pop_front();
          check($sformatf("cfg%0d smpl_vld", g), 64'(smpl_vld), 64'(1) << s);
          check($sformatf("cfg%0d results", g), 64'(results), 64'(rexp));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (busy_w[0] !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin n_chk++; $display("FAIL %s timeout: busy %b expected 0", name, busy_w[0]); end
  endtask

  task automatic wait_vld(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (vld_w[0] === 8'h0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin n_chk++; $display("FAIL %s timeout: smpl_vld %0h expected nonzero", name, vld_w[0]); end
  endtask

  task automatic do_conv(input string name);
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    check({name, " busy rise"}, 64'(busy_w[0]), 64'h1);
    wait_idle(name);
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("%s cfg%0d busy", name, k), 64'(busy_w[k]), 64'h0);
      check($sformatf("%s cfg%0d SS_n", name, k), 64'(ssn_w[k]), 64'h1);
      check($sformatf("%s cfg%0d results zero", name, k), 64'(zero_w[k]), 64'h1);
      check($sformatf("%s cfg%0d smpl_vld", name, k), 64'(vld_w[k]), 64'h0);
    end
  endtask

  initial begin : main
    logic [15:0] filt_exp [4];
    int idle_cyc, pulses, t;
    filt_exp[0] = 16'h400; filt_exp[1] = 16'h300; filt_exp[2] = 16'h240; filt_exp[3] = 16'h1B0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed values: raw capture of 0xA5A and the IIR step response on slot 0
    force_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      do_conv($sformatf("directed %0d", k));
      if (k == 1 || k == 5) check($sformatf("raw ch0 conv %0d", k), 64'(r0_w[0]), 64'hA5A);
      if (k % 3 == 1) check($sformatf("iir slot0 conv %0d", k), 64'(r0_w[1]), 64'(filt_exp[k/3]));
    end
    force_mode = 1'b0;

    // nxt held through busy: each IDLE cycle carries exactly one update strobe
    @(posedge clk); #1 nxt = 1'b1;
    @(negedge clk);
    idle_cyc = 0; pulses = 0;
    repeat (800) begin
      @(negedge clk);
      if (busy_w[0] === 1'b0) idle_cyc++;
      if (vld_w[0] !== 8'h0) pulses++;
    end
    nxt = 1'b0;
    check("nxt spam idle visits vs updates", 64'(idle_cyc), 64'(pulses));
    check("nxt spam enough updates", 64'(pulses >= 2), 64'h1);
    wait_idle("nxt spam drain");

    // Random launches with ignored nxt pulses during the conversion
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      @(posedge clk); #1 nxt = 1'b1;
      @(posedge clk); #1 nxt = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        repeat ($urandom_range(2, 60)) @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
      end
      wait_idle($sformatf("random %0d", k));
    end

    // Auto mode: one IDLE cycle between conversions, then drop auto_en mid-flight
    @(posedge clk); #1 auto_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nxt = 1'($urandom);
      wait_vld($sformatf("auto %0d", k));
      check($sformatf("auto %0d idle cycle busy", k), 64'(busy_w[0]), 64'h0);
      @(negedge clk);
      check($sformatf("auto %0d relaunch busy", k), 64'(busy_w[0]), 64'h1);
    end
    nxt = 1'b0;
    repeat (100) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_idle("auto drop");
    repeat (20) @(negedge clk);
    check("auto dropped rests idle", 64'(busy_w[0]), 64'h0);

    // Reset in DEAD: abort everything, next command must address slot 0
    while (cfg[0].slot_m == 0) do_conv("advance slot");
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    t = 0;
    while (ssn_w[0] !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) begin n_chk++; $display("FAIL dead wait timeout: SS_n %b expected 1", ssn_w[0]); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("dead reset");
    @(posedge clk); #1 rst_n = 1'b1;
    do_conv("after dead reset");
    check("post-reset slot advanced to 1", 64'(cfg[0].slot_m), 64'h1);

    repeat (5) @(negedge clk);
    check("cfg0 all updates seen", 64'(cfg[0].exp_res_q.size()), 64'h0);
    check("cfg1 all updates seen", 64'(cfg[1].exp_res_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
